// File: rtl/q_meter.sv
// Ring-down Q meter: counts synchronized oscillator cycles between the upper and
// lower envelope crossings after each new i_ref and holds the result with a ready level.
module q_meter #(
    parameter int BUS_WIDTH     = 10,
    parameter int SETTLE_CYCLES = 64,
    parameter int TIMEOUT       = 65535,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 osc_in,
    input  logic                 env_hi,
    input  logic                 env_lo,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SC_W-1:0]      SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [WD_W-1:0]      WD_LAST     = WD_W'(TIMEOUT - 1);
    localparam logic [BUS_WIDTH-1:0] COUNT_MAX   = '1;

    localparam int IDX_OSC = 0;
    localparam int IDX_HI  = 1;
    localparam int IDX_LO  = 2;

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_COUNT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [2:0] async_in;
    logic [2:0] synced;
    logic [2:0] delayed;

    assign async_in = {env_lo, env_hi, osc_in};

    // One synchronizer chain plus one edge-detect flop per asynchronous input.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   dly_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    chain_reg <= '0;
                    dly_reg   <= 1'b0;
                end else begin
                    chain_reg <= (chain_reg << 1) | SYNC_STAGES'(async_in[gi]);
                    dly_reg   <= chain_reg[SYNC_STAGES-1];
                end
            end

            assign synced[gi]  = chain_reg[SYNC_STAGES-1];
            assign delayed[gi] = dly_reg;
        end
    endgenerate

    logic osc_rise;
    logic hi_fall;
    logic lo_fall;

    assign osc_rise = synced[IDX_OSC] & ~delayed[IDX_OSC];
    assign hi_fall  = ~synced[IDX_HI] & delayed[IDX_HI];
    assign lo_fall  = ~synced[IDX_LO] & delayed[IDX_LO];

    logic [BUS_WIDTH-1:0] i_ref_q_reg;
    logic                 chg;

    assign chg = (i_ref != i_ref_q_reg);

    logic [1:0]           state_reg,   state_next;
    logic [SC_W-1:0]      settle_reg,  settle_next;
    logic [WD_W-1:0]      wd_reg,      wd_next;
    logic [BUS_WIDTH-1:0] count_reg,   count_next;
    logic [BUS_WIDTH-1:0] q_reg,       q_next;
    logic                 ready_reg,   ready_next;
    logic                 timeout_reg, timeout_next;

    logic [BUS_WIDTH-1:0] count_inc;

    assign count_inc = (count_reg == COUNT_MAX) ? COUNT_MAX : count_reg + 1'b1;

    always_comb begin
        state_next   = state_reg;
        settle_next  = settle_reg;
        wd_next      = wd_reg;
        count_next   = count_reg;
        q_next       = q_reg;
        ready_next   = ready_reg;
        timeout_next = timeout_reg;

        // A new operating point aborts whatever is in progress; q keeps its last value.
        if (chg) begin
            state_next   = ST_SETTLE;
            settle_next  = '0;
            count_next   = '0;
            ready_next   = 1'b0;
            timeout_next = 1'b0;
        end else begin
            case (state_reg)
                ST_SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        state_next = ST_ARM;
                        wd_next    = '0;
                    end else begin
                        settle_next = settle_reg + 1'b1;
                    end
                end
                ST_ARM: begin
                    wd_next = wd_reg + 1'b1;
                    if (hi_fall) begin
                        state_next = ST_COUNT;
                        count_next = '0;
                    end else if (wd_reg == WD_LAST) begin
                        // Envelope still high means it never decayed; low means it never rang.
                        state_next   = ST_DONE;
                        ready_next   = 1'b1;
                        timeout_next = 1'b1;
                        q_next       = synced[IDX_HI] ? COUNT_MAX : '0;
                    end
                end
                ST_COUNT: begin
                    wd_next = wd_reg + 1'b1;
                    if (lo_fall) begin
                        state_next = ST_DONE;
                        ready_next = 1'b1;
                        q_next     = osc_rise ? count_inc : count_reg;
                    end else if (wd_reg == WD_LAST) begin
                        state_next   = ST_DONE;
                        ready_next   = 1'b1;
                        timeout_next = 1'b1;
                        q_next       = COUNT_MAX;
                    end else if (osc_rise) begin
                        count_next = count_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_ref_q_reg <= '0;
            state_reg   <= ST_SETTLE;
            settle_reg  <= '0;
            wd_reg      <= '0;
            count_reg   <= '0;
            q_reg       <= '0;
            ready_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            i_ref_q_reg <= i_ref;
            state_reg   <= state_next;
            settle_reg  <= settle_next;
            wd_reg      <= wd_next;
            count_reg   <= count_next;
            q_reg       <= q_next;
            ready_reg   <= ready_next;
            timeout_reg <= timeout_next;
        end
    end

    assign q_measured = q_reg;
    assign ready      = ready_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_q_meter.sv
// Bench for q_meter: input-domain reference model feeds an expectation queue that a
// separate monitor drains on every rising edge of ready.
module tb_q_meter;
    localparam int BW     = 10;
    localparam int SETTLE = 64;
    localparam int TMO    = 10000;
    localparam int SYNC   = 2;
    localparam int QMAX   = (1 << BW) - 1;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic [BW-1:0] i_ref  = '0;
    logic          osc_in = 1'b0;
    logic          env_hi = 1'b0;
    logic          env_lo = 1'b0;
    logic [BW-1:0] q_measured;
    logic          ready;
    logic          timeout;

    q_meter #(
        .BUS_WIDTH    (BW),
        .SETTLE_CYCLES(SETTLE),
        .TIMEOUT      (TMO),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_ref     (i_ref),
        .osc_in    (osc_in),
        .env_hi    (env_hi),
        .env_lo    (env_lo),
        .q_measured(q_measured),
        .ready     (ready),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    // Reference model state, tracked on the undelayed inputs as driven.
    bit m_osc = 0, m_hi = 0, m_lo = 0;
    bit m_armed = 0, m_counting = 0;
    int m_cnt = 0, m_raw = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit osc_val(input int ph, input int period, input int hl);
        return (ph % period) < hl;
    endfunction

    function automatic logic [BW-1:0] pick_ref();
        logic [BW-1:0] v;
        do v = BW'($urandom_range(0, QMAX)); while (v == i_ref);
        return v;
    endfunction

    // Q = oscillator rises after the upper crossing up to and including the lower one.
    task automatic tick(input bit osc, input bit hi, input bit lo);
        @(negedge clk);
        osc_in = osc;
        env_hi = hi;
        env_lo = lo;
        if (m_counting) begin
            if (osc && !m_osc) begin
                m_raw++;
                if (m_cnt < QMAX) m_cnt++;
            end
            if (m_lo && !lo) begin
                m_counting = 0;
                m_armed    = 0;
                exp_q.push_back('{q: m_cnt, to: 1'b0});
            end
        end else if (m_armed && m_hi && !hi) begin
            m_counting = 1;
            m_cnt      = 0;
            m_raw      = 0;
        end
        m_osc = osc;
        m_hi  = hi;
        m_lo  = lo;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int k;
        k = 0;
        while (!ready && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, ready, 1);
    endtask

    // abort_kind: 0 none, 1 i_ref change, 2 reset, applied after abort_at counted rises.
    task automatic run_meas(input int n, input int period, input bit coincide, input int ref_v,
                            input int abort_kind, input int abort_at, input int ph0);
        int hl;
        int ph;
        bit o;
        bit fin;
        hl = $urandom_range(3, period - 3);
        ph = (ph0 < 0) ? $urandom_range(0, period - 1) : ph0;
        m_counting = 0;
        m_armed    = 0;
        tick(1'b0, 1'b1, 1'b1);
        if (ref_v >= 0) i_ref = BW'(ref_v);
        repeat (SETTLE + 8) begin
            ph++;
            tick(osc_val(ph, period, hl), 1'b1, 1'b1);
        end
        m_armed = 1;
        ph++;
        tick(osc_val(ph, period, hl), 1'b0, 1'b1);
        fin = 0;
        while (!fin) begin
            ph++;
            o = osc_val(ph, period, hl);
            if (coincide && o && !m_osc && m_raw == n - 1) begin
                tick(o, 1'b0, 1'b0);
                fin = 1;
            end else if (!coincide && m_raw == n) begin
                tick(o, 1'b0, 1'b0);
                fin = 1;
            end else begin
                tick(o, 1'b0, 1'b1);
                if (abort_kind != 0 && m_raw == abort_at) begin
                    m_counting = 0;
                    m_armed    = 0;
                    if (abort_kind == 1) begin
                        i_ref = pick_ref();
                    end else begin
                        #2 rst = 1'b0;
                        #1;
                        check("rst_mid_count_q", q_measured, 0);
                        check("rst_mid_count_ready", ready, 0);
                        check("rst_mid_count_timeout", timeout, 0);
                        @(negedge clk);
                        rst = 1'b1;
                    end
                    fin = 1;
                end
            end
        end
        if (abort_kind == 0) wait_ready("meas_ready", 40);
    endtask

    // kind: 0 env_hi stuck high, 1 env_hi falls but env_lo never does, 2 no oscillation.
    task automatic run_timeout(input int kind, input int ref_v);
        int waited;
        int ph;
        bit hi;
        bit in_win;
        m_counting = 0;
        m_armed    = 0;
        tick(1'b0, kind != 2, 1'b1);
        i_ref = BW'(ref_v);
        exp_q.push_back('{q: (kind == 2) ? 0 : QMAX, to: 1'b1});
        tick(1'b0, kind != 2, 1'b1);
        waited = 2;
        ph     = 0;
        while (!ready && waited < SETTLE + TMO + 20) begin
            ph++;
            hi = (kind == 0) || (kind == 1 && waited < SETTLE + 8);
            tick((kind != 2) && osc_val(ph, 8, 4), hi, 1'b1);
            waited++;
        end
        in_win = ready && (waited >= SETTLE + TMO - 1) && (waited <= SETTLE + TMO + 5);
        check("timeout_latency_window", in_win, 1);
        check("timeout_q", q_measured, (kind == 2) ? 0 : QMAX);
        check("timeout_flag", timeout, 1);
    endtask

    // Monitor: every new ready level must match the oldest outstanding expectation.
    bit ready_q = 0;
    always @(posedge clk) begin
        #1;
        if (ready && !ready_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready: q_measured=%0d timeout=%0b, required no ready",
                         q_measured, timeout);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_q_measured", q_measured, mon_e.q);
                check("sb_timeout", timeout, mon_e.to);
            end
        end
        ready_q = ready;
    end

    initial begin
        bit seen;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            osc_in = 1'($urandom_range(0, 1));
            env_hi = 1'($urandom_range(0, 1));
            env_lo = 1'($urandom_range(0, 1));
            i_ref  = BW'($urandom_range(0, QMAX));
        end
        check("reset_q", q_measured, 0);
        check("reset_ready", ready, 0);
        check("reset_timeout", timeout, 0);
        tick(1'b0, 1'b1, 1'b1);
        i_ref = '0;
        rst   = 1'b1;
        seen  = 0;
        repeat (SETTLE + SYNC + 1) begin
            tick(1'b0, 1'b1, 1'b1);
            seen |= ready;
        end
        check("ready_low_after_reset", seen, 0);

        // First measurement arms without any i_ref change.
        run_meas(25, 8, 0, -1, 0, 0, -1);

        run_meas(110, 8, 0, 512, 0, 0, -1);
        check("normal_q", q_measured, 110);
        check("normal_timeout", timeout, 0);
        i_ref = 10'd300;
        @(posedge clk);
        #1;
        check("ready_drop_after_chg", ready, 0);
        check("q_hold_after_chg", q_measured, 110);

        run_meas(120, 8, 0, -1, 1, 60, -1);
        run_meas(40, 8, 0, pick_ref(), 0, 0, -1);
        check("rerun_q", q_measured, 40);

        // Phase 7 puts a rise on the upper crossing; the lower crossing also lands on a rise.
        run_meas(110, 8, 1, pick_ref(), 0, 0, 7);
        check("coincident_q", q_measured, 110);

        run_meas(1500, 6, 0, pick_ref(), 0, 0, -1);
        check("saturation_q", q_measured, QMAX);

        run_meas(200, 8, 0, pick_ref(), 2, 50, -1);

        run_timeout(0, pick_ref());
        run_timeout(1, pick_ref());
        run_timeout(2, pick_ref());

        for (int i = 0; i < 6; i++) begin
            run_meas($urandom_range(1, 300), $urandom_range(6, 10), 1'($urandom_range(0, 1)),
                     pick_ref(), 0, 0, -1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #20000000;
        checks++;
        fails++;
        $display("FAIL global_time_limit: simulation still running, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
